// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the sum_acc block accumulator.
// Optional saturation is selected with the SUM_ACC_SAT_EN macro.
package sum_acc_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int SUM_IN_W  = 9;
   localparam int ACC_W_DEF = 16;
   localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/sum_acc_add.sv
// Combinational ACC_W adder with carry-out for the block accumulator.
// With SUM_ACC_SAT_EN defined the sum clamps to all-ones on carry-out.
module sum_acc_add
   import sum_acc_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);

   logic [ACC_W:0] raw_s;

   // Widened add; the top bit is the carry out of ACC_W.
   always_comb begin
      raw_s = {1'b0, a} + {1'b0, b};
      carry = raw_s[ACC_W];
`ifdef SUM_ACC_SAT_EN
      if (raw_s[ACC_W]) begin
         sum = {ACC_W{1'b1}};
      end else begin
         sum = raw_s[ACC_W-1:0];
      end
`else
      sum = raw_s[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/sum_acc.sv
// Block accumulator for the adder's {cout,sum} stream; emits one total per block.
// Build with SUM_ACC_SAT_EN to saturate instead of wrapping on overflow.
module sum_acc
   import sum_acc_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_sum,
   input  logic             in_cout,
   input  logic [CNT_W-1:0] blk_len,
   input  logic             clr,
   output logic             acc_valid,
   output logic [ACC_W-1:0] acc_out,
   output logic             acc_ovf,
   output logic             busy
);

   state_t           state_r, state_nx;
   logic [ACC_W-1:0] acc_r, acc_nx;
   logic [CNT_W-1:0] cnt_r, cnt_nx;
   logic [CNT_W-1:0] len_r, len_nx;
   logic             ovf_r, ovf_nx;

   logic [ACC_W-1:0] v_ext_s;
   logic [CNT_W-1:0] len_first_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic [ACC_W-1:0] add_sum_s;
   logic             add_carry_s;
   logic             ovf_sum_s;
   logic             fin_s;
   logic [ACC_W-1:0] fin_acc_s;
   logic             fin_ovf_s;

   sum_acc_add #(.ACC_W(ACC_W)) u_add (
      .a     (acc_r),
      .b     (v_ext_s),
      .sum   (add_sum_s),
      .carry (add_carry_s)
   );

   // Sample widening, effective block length and counter increment.
   always_comb begin
      v_ext_s     = ACC_W'({in_cout, in_sum});
      cnt_inc_s   = cnt_r + CNT_W'(1'b1);
      ovf_sum_s   = ovf_r | add_carry_s;
      if (blk_len == '0) begin
         len_first_s = CNT_W'(1'b1);
      end else begin
         len_first_s = blk_len;
      end
   end

   // Next-state logic; a finishing sample leaves the FSM ready for a new block.
   always_comb begin
      state_nx  = state_r;
      acc_nx    = acc_r;
      cnt_nx    = cnt_r;
      len_nx    = len_r;
      ovf_nx    = ovf_r;
      fin_s     = 1'b0;
      fin_acc_s = acc_r;
      fin_ovf_s = ovf_r;
      if (clr) begin
         state_nx = ST_IDLE;
         acc_nx   = '0;
         cnt_nx   = '0;
      end else if (in_valid) begin
         case (state_r)
            ST_IDLE: begin
               len_nx = len_first_s;
               ovf_nx = 1'b0;
               if (len_first_s == CNT_W'(1'b1)) begin
                  fin_s     = 1'b1;
                  fin_acc_s = v_ext_s;
                  fin_ovf_s = 1'b0;
                  acc_nx    = '0;
                  cnt_nx    = '0;
               end else begin
                  acc_nx   = v_ext_s;
                  cnt_nx   = CNT_W'(1'b1);
                  state_nx = ST_RUN;
               end
            end
            ST_RUN: begin
               ovf_nx = ovf_sum_s;
               if (cnt_inc_s == len_r) begin
                  fin_s     = 1'b1;
                  fin_acc_s = add_sum_s;
                  fin_ovf_s = ovf_sum_s;
                  acc_nx    = '0;
                  cnt_nx    = '0;
                  state_nx  = ST_IDLE;
               end else begin
                  acc_nx = add_sum_s;
                  cnt_nx = cnt_inc_s;
               end
            end
            default: begin
               state_nx = ST_IDLE;
               acc_nx   = '0;
               cnt_nx   = '0;
            end
         endcase
      end else begin
         state_nx = state_r;
      end
   end

   // State and output registers; result registers only move on a finish.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         acc_r     <= '0;
         cnt_r     <= '0;
         len_r     <= '0;
         ovf_r     <= 1'b0;
         acc_valid <= 1'b0;
         acc_out   <= '0;
         acc_ovf   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_r   <= state_nx;
         acc_r     <= acc_nx;
         cnt_r     <= cnt_nx;
         len_r     <= len_nx;
         ovf_r     <= ovf_nx;
         acc_valid <= fin_s;
         busy      <= (state_nx == ST_RUN);
         if (fin_s) begin
            acc_out <= fin_acc_s;
            acc_ovf <= fin_ovf_s;
         end
      end
   end

endmodule
